// File: rtl/video_scale_pkg.sv
// Shared constants, FSM encoding and fixed-point helper for the video scale-factor controller.
package video_scale_pkg;

  localparam int VIN_XRES_DFLT = 960;
  localparam int VIN_YRES_DFLT = 540;
  localparam int FRAC_BITS     = 16;
  localparam int DIV_ITER      = 26;
  localparam int CNT_W         = 10;
  localparam logic [31:0] SCALE_UNITY = 32'h0001_0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIV_W  = 2'd1,
    ST_DIV_H  = 2'd2,
    ST_COMMIT = 2'd3
  } scale_state_e;

  // Quotient to 16.16 scale word: zero-extend, then add the +1 bias.
  function automatic logic [31:0] to_scale(input logic [DIV_ITER-1:0] q);
    return 32'(q) + 32'd1;
  endfunction

endpackage

// File: rtl/video_scale_ctrl_serial_div.sv
// Restoring serial divider, one quotient bit per clock. The start cycle
// already performs the first iteration, so done pulses DVD_W cycles after start.
module serial_div #(
  parameter int DVD_W = 26,
  parameter int DVS_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             done
);

  localparam int REM_W = DVS_W + 1;
  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DVD_W - 1);

  logic [REM_W-1:0] rem_r;
  logic [REM_W-1:0] src_rem_s;
  logic [REM_W-1:0] rem_nx_s;
  logic [REM_W:0]   shf_s;
  logic [DVD_W-1:0] dq_r;
  logic [DVD_W-1:0] src_dq_s;
  logic [DVD_W-1:0] dq_nx_s;
  logic [DVS_W-1:0] dvs_r;
  logic [DVS_W-1:0] src_dvs_s;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic             ge_s;

  // One restoring step on either the freshly loaded operands or the running state
  always_comb begin
    src_rem_s = rem_r;
    src_dq_s  = dq_r;
    src_dvs_s = dvs_r;
    if (start) begin
      src_rem_s = {REM_W{1'b0}};
      src_dq_s  = dividend;
      src_dvs_s = divisor;
    end else begin
      src_rem_s = rem_r;
      src_dq_s  = dq_r;
      src_dvs_s = dvs_r;
    end
    shf_s = {src_rem_s, src_dq_s[DVD_W-1]};
    ge_s  = (shf_s >= {2'b00, src_dvs_s});
    if (ge_s) begin
      rem_nx_s = REM_W'(shf_s - {2'b00, src_dvs_s});
    end else begin
      rem_nx_s = REM_W'(shf_s);
    end
    dq_nx_s = {src_dq_s[DVD_W-2:0], ge_s};
  end

  // Divider state, iteration counter and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r <= {REM_W{1'b0}};
      dq_r  <= {DVD_W{1'b0}};
      dvs_r <= {DVS_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      run_r <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      rem_r <= rem_nx_s;
      dq_r  <= dq_nx_s;
      dvs_r <= divisor;
      cnt_r <= CNT_W'(1);
      run_r <= 1'b1;
      done  <= 1'b0;
    end else if (run_r) begin
      rem_r <= rem_nx_s;
      dq_r  <= dq_nx_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (cnt_r == LAST_CNT) begin
        run_r <= 1'b0;
        done  <= 1'b1;
      end else begin
        done  <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = dq_r;

endmodule

// File: rtl/video_scale_ctrl.sv
// Zoom-level controller for the nearest-neighbour downscaler; commits cnt_x/cnt_y
// and 16.16 scale words atomically in vsync. Macro VIDEO_SCALE_SWEEP_EN enables auto-sweep.
module video_scale_ctrl
  import video_scale_pkg::*;
#(
  parameter int VIN_XRES  = VIN_XRES_DFLT,
  parameter int VIN_YRES  = VIN_YRES_DFLT,
  parameter int STEP_X    = 16,
  parameter int STEP_Y    = 9,
  parameter int MAX_LEVEL = 40
`ifdef VIDEO_SCALE_SWEEP_EN
  ,
  parameter int SWEEP_FRAMES = 4
`endif
) (
  input  logic             pixclk_in,
  input  logic             rst_in,
  input  logic             vs_in,
  input  logic             zoom_up,
  input  logic             zoom_dn,
  output logic [CNT_W-1:0] cnt_x,
  output logic [CNT_W-1:0] cnt_y,
  output logic [31:0]      scaler_width,
  output logic [31:0]      scaler_height,
  output logic             cfg_update,
  output logic             busy
);

  localparam logic [DIV_ITER-1:0] DVD_X   = DIV_ITER'(VIN_XRES << FRAC_BITS);
  localparam logic [DIV_ITER-1:0] DVD_Y   = DIV_ITER'(VIN_YRES << FRAC_BITS);
  localparam logic [CNT_W-1:0]    XRES_C  = CNT_W'(VIN_XRES);
  localparam logic [CNT_W-1:0]    YRES_C  = CNT_W'(VIN_YRES);
  localparam logic [CNT_W-1:0]    STEPX_C = CNT_W'(STEP_X);
  localparam logic [CNT_W-1:0]    STEPY_C = CNT_W'(STEP_Y);
  localparam logic [5:0]          MAXL_C  = 6'(MAX_LEVEL);

  scale_state_e        state_r;
  scale_state_e        state_nx_s;
  logic [5:0]          level_r;
  logic [5:0]          lvl_nx_s;
  logic                lvl_chg_s;
  logic                pending_r;
  logic                vs_d_r;
  logic                vs_rise_s;
  logic [CNT_W-1:0]    tx_s;
  logic [CNT_W-1:0]    ty_s;
  logic [CNT_W-1:0]    tx_r;
  logic [CNT_W-1:0]    ty_r;
  logic [31:0]         qw_r;
  logic [31:0]         qh_r;
  logic                div_start_s;
  logic [DIV_ITER-1:0] div_dvd_s;
  logic [CNT_W-1:0]    div_dvs_s;
  logic [DIV_ITER-1:0] div_q_s;
  logic                div_done_s;
  logic                capture_s;
  logic                latch_w_s;
  logic                latch_h_s;
  logic                commit_s;
  logic                abort_s;

  assign vs_rise_s = vs_in & ~vs_d_r;
  assign tx_s      = CNT_W'(level_r) * STEPX_C;
  assign ty_s      = CNT_W'(level_r) * STEPY_C;

`ifdef VIDEO_SCALE_SWEEP_EN
  localparam logic [7:0] FRM_LAST = 8'(SWEEP_FRAMES - 1);

  logic [7:0] frm_cnt_r;
  logic       dir_up_r;
  logic       step_s;
  logic       go_up_s;

  // Triangle sweep: one level step every SWEEP_FRAMES frames, turning at the ends
  always_comb begin
    step_s    = vs_rise_s && (frm_cnt_r == FRM_LAST);
    go_up_s   = dir_up_r ? (level_r != MAXL_C) : (level_r == 6'd0);
    lvl_nx_s  = level_r;
    lvl_chg_s = 1'b0;
    if (step_s) begin
      lvl_chg_s = 1'b1;
      lvl_nx_s  = go_up_s ? (level_r + 6'd1) : (level_r - 6'd1);
    end else begin
      lvl_chg_s = 1'b0;
      lvl_nx_s  = level_r;
    end
  end

  // Sweep frame counter and direction
  always_ff @(posedge pixclk_in) begin
    if (rst_in) begin
      frm_cnt_r <= 8'd0;
      dir_up_r  <= 1'b1;
    end else if (vs_rise_s) begin
      frm_cnt_r <= step_s ? 8'd0 : (frm_cnt_r + 8'd1);
      if (step_s) begin
        dir_up_r <= go_up_s;
      end
    end
  end
`else
  // Key-driven saturating level; simultaneous up/down cancels
  always_comb begin
    lvl_nx_s  = level_r;
    lvl_chg_s = 1'b0;
    if (zoom_up && !zoom_dn && (level_r != MAXL_C)) begin
      lvl_nx_s  = level_r + 6'd1;
      lvl_chg_s = 1'b1;
    end else if (zoom_dn && !zoom_up && (level_r != 6'd0)) begin
      lvl_nx_s  = level_r - 6'd1;
      lvl_chg_s = 1'b1;
    end else begin
      lvl_nx_s  = level_r;
      lvl_chg_s = 1'b0;
    end
  end
`endif

  // Next-state logic and divider sequencing
  always_comb begin
    state_nx_s  = state_r;
    div_start_s = 1'b0;
    div_dvd_s   = {DIV_ITER{1'b0}};
    div_dvs_s   = {CNT_W{1'b0}};
    capture_s   = 1'b0;
    latch_w_s   = 1'b0;
    latch_h_s   = 1'b0;
    commit_s    = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (vs_rise_s && pending_r) begin
          capture_s   = 1'b1;
          div_start_s = 1'b1;
          div_dvd_s   = DVD_X;
          div_dvs_s   = XRES_C - tx_s;
          state_nx_s  = ST_DIV_W;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_DIV_W: begin
        if (!vs_in) begin
          abort_s     = 1'b1;
          state_nx_s  = ST_IDLE;
        end else if (div_done_s) begin
          latch_w_s   = 1'b1;
          div_start_s = 1'b1;
          div_dvd_s   = DVD_Y;
          div_dvs_s   = YRES_C - ty_r;
          state_nx_s  = ST_DIV_H;
        end else begin
          state_nx_s  = ST_DIV_W;
        end
      end
      ST_DIV_H: begin
        if (!vs_in) begin
          abort_s    = 1'b1;
          state_nx_s = ST_IDLE;
        end else if (div_done_s) begin
          latch_h_s  = 1'b1;
          state_nx_s = ST_COMMIT;
        end else begin
          state_nx_s = ST_DIV_H;
        end
      end
      ST_COMMIT: begin
        commit_s   = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Control state: FSM, level, pending flag, captured shrink and quotients
  always_ff @(posedge pixclk_in) begin
    if (rst_in) begin
      state_r   <= ST_IDLE;
      vs_d_r    <= 1'b0;
      level_r   <= 6'd0;
      pending_r <= 1'b0;
      tx_r      <= {CNT_W{1'b0}};
      ty_r      <= {CNT_W{1'b0}};
      qw_r      <= SCALE_UNITY;
      qh_r      <= SCALE_UNITY;
    end else begin
      state_r <= state_nx_s;
      vs_d_r  <= vs_in;
      level_r <= lvl_nx_s;
      // a level change in the capture cycle must survive for the next frame
      if (lvl_chg_s || abort_s) begin
        pending_r <= 1'b1;
      end else if (capture_s) begin
        pending_r <= 1'b0;
      end
      if (capture_s) begin
        tx_r <= tx_s;
        ty_r <= ty_s;
      end
      if (latch_w_s) begin
        qw_r <= to_scale(div_q_s);
      end
      if (latch_h_s) begin
        qh_r <= to_scale(div_q_s);
      end
    end
  end

  // Committed configuration, update strobe and busy flag
  always_ff @(posedge pixclk_in) begin
    if (rst_in) begin
      cnt_x         <= {CNT_W{1'b0}};
      cnt_y         <= {CNT_W{1'b0}};
      scaler_width  <= SCALE_UNITY;
      scaler_height <= SCALE_UNITY;
      cfg_update    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      cfg_update <= commit_s;
      if (commit_s) begin
        cnt_x         <= tx_r;
        cnt_y         <= ty_r;
        scaler_width  <= qw_r;
        scaler_height <= qh_r;
      end
      if (capture_s) begin
        busy <= 1'b1;
      end else if (commit_s || abort_s) begin
        busy <= 1'b0;
      end
    end
  end

  serial_div #(
    .DVD_W (DIV_ITER),
    .DVS_W (CNT_W)
  ) u_div (
    .clk      (pixclk_in),
    .rst      (rst_in),
    .start    (div_start_s),
    .dividend (div_dvd_s),
    .divisor  (div_dvs_s),
    .quotient (div_q_s),
    .done     (div_done_s)
  );

endmodule
